// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius sprite path.
package genius_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_READY,
    ST_SHOW,
    ST_GAP,
    ST_LOSE,
    ST_WIN
  } state_e;

  localparam int FLAG_PWR        = 0;
  localparam int FLAG_WIN        = 1;
  localparam int FLAG_LOSE       = 2;
  localparam int FLAG_COLOR_BASE = 3;

  // Colour 0 lands on the MSB of the flag vector, the last colour on FLAG_COLOR_BASE.
  function automatic int color_flag_bit(input int num_colors, input int idx);
    return FLAG_COLOR_BASE + (num_colors - 1 - idx);
  endfunction

endpackage

// File: rtl/genius_down_counter.sv
// Loadable down-counter that parks at zero and reports it.
module genius_down_counter #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load wins over decrement; decrement never goes below zero.
  always_ff @(posedge CLK) begin
    if (RESET)                      cnt_q <= '0;
    else if (load_i)                cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/genius_sprite_sequencer.sv
// Maps controller events to registered one-hot sprite flags with
// colour hold/gap timing and a one-deep pending colour slot.
module genius_sprite_sequencer
  import genius_pkg::*;
#(
  parameter int NUM_COLORS  = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int END_CYCLES  = 3,
  parameter int CW          = $clog2(NUM_COLORS)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  PWR_BTN,
  input  logic                  COLOR_VALID,
  input  logic [CW-1:0]         COLOR_IDX,
  output logic                  COLOR_ACK,
  input  logic                  LOSE_REQ,
  input  logic                  WIN_REQ,
  output logic [NUM_COLORS+2:0] SPRITES_FLAGS,
  output logic                  BUSY
);

  localparam int FW   = NUM_COLORS + 3;
  localparam int M1   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAXC = (M1 > END_CYCLES) ? M1 : END_CYCLES;
  localparam int CNTW = $clog2(MAXC + 1);

  localparam logic [CNTW-1:0] HOLD_LD = CNTW'(HOLD_CYCLES - 1);
  localparam logic [CNTW-1:0] END_LD  = CNTW'(END_CYCLES - 1);
  localparam logic [CNTW-1:0] GAP_LD  = CNTW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   cur_idx_q, cur_idx_d;
  logic            pend_vld_q, pend_vld_d;
  logic [CW-1:0]   pend_idx_q, pend_idx_d;
  logic [FW-1:0]   flags_q, flags_d;
  logic            busy_q, busy_d;

  logic            ld, dec, cnt_zero, ack;
  logic [CNTW-1:0] ld_val;
  logic            req_ok;

  assign req_ok = COLOR_VALID && (int'(COLOR_IDX) < NUM_COLORS);

  genius_down_counter #(.W(CNTW)) u_cnt (
    .CLK        (CLK),
    .RESET      (RESET),
    .load_i     (ld),
    .load_val_i (ld_val),
    .dec_i      (dec),
    .zero_o     (cnt_zero)
  );

  // State, latched colours and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_OFF;
      cur_idx_q  <= '0;
      pend_vld_q <= 1'b0;
      pend_idx_q <= '0;
      flags_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      pend_vld_q <= pend_vld_d;
      pend_idx_q <= pend_idx_d;
      flags_q    <= flags_d;
      busy_q     <= busy_d;
    end
  end

  // Next state, counter control, colour acceptance.
  always_comb begin
    logic expire, take, direct;
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    pend_vld_d = pend_vld_q;
    pend_idx_d = pend_idx_q;
    ld         = 1'b0;
    ld_val     = '0;
    dec        = 1'b0;
    ack        = 1'b0;
    expire     = 1'b0;
    take       = 1'b0;
    direct     = 1'b0;
    if (!RESET) begin
      unique case (state_q)
        ST_OFF: if (PWR_BTN) state_d = ST_READY;
        ST_READY: begin
          if (LOSE_REQ) begin
            state_d = ST_LOSE; ld = 1'b1; ld_val = END_LD;
          end else if (WIN_REQ) begin
            state_d = ST_WIN;  ld = 1'b1; ld_val = END_LD;
          end else if (req_ok) begin
            ack = 1'b1; cur_idx_d = COLOR_IDX;
            state_d = ST_SHOW; ld = 1'b1; ld_val = HOLD_LD;
          end
        end
        ST_SHOW, ST_GAP: begin
          if (LOSE_REQ || WIN_REQ) begin
            // Preemption flushes the slot and acks nothing.
            state_d    = LOSE_REQ ? ST_LOSE : ST_WIN;
            ld         = 1'b1;
            ld_val     = END_LD;
            pend_vld_d = 1'b0;
          end else begin
            take   = req_ok && !pend_vld_q;
            expire = cnt_zero && (state_q == ST_GAP || GAP_CYCLES == 0);
            // A request taken into an empty slot on the expiry edge would
            // otherwise be stranded in READY, so it starts showing directly.
            direct = expire && !pend_vld_q && take;
            ack    = take;
            if (!cnt_zero) begin
              dec = 1'b1;
            end else if (!expire) begin
              state_d = ST_GAP; ld = 1'b1; ld_val = GAP_LD;
            end else if (pend_vld_q) begin
              state_d = ST_SHOW; cur_idx_d = pend_idx_q; pend_vld_d = 1'b0;
              ld = 1'b1; ld_val = HOLD_LD;
            end else if (direct) begin
              state_d = ST_SHOW; cur_idx_d = COLOR_IDX;
              ld = 1'b1; ld_val = HOLD_LD;
            end else begin
              state_d = ST_READY;
            end
            if (take && !direct) begin
              pend_vld_d = 1'b1;
              pend_idx_d = COLOR_IDX;
            end
          end
        end
        ST_LOSE: if (cnt_zero && !LOSE_REQ) state_d = ST_OFF; else dec = 1'b1;
        ST_WIN:  if (cnt_zero && !WIN_REQ)  state_d = ST_OFF; else dec = 1'b1;
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Moore flags and busy derived from the next state.
  always_comb begin
    flags_d = '0;
    unique case (state_d)
      ST_READY, ST_GAP: flags_d = FW'(1) << FLAG_PWR;
      ST_SHOW:  flags_d = (FW'(1) << FLAG_PWR)
                        | (FW'(1) << color_flag_bit(NUM_COLORS, int'(cur_idx_d)));
      ST_LOSE:  flags_d = FW'(1) << FLAG_LOSE;
      ST_WIN:   flags_d = FW'(1) << FLAG_WIN;
      default:  flags_d = '0;
    endcase
    busy_d = (state_d == ST_SHOW) || (state_d == ST_GAP) || pend_vld_d;
  end

  assign COLOR_ACK     = ack;
  assign SPRITES_FLAGS = flags_q;
  assign BUSY          = busy_q;

endmodule

// File: tb/tb_genius_sprite_sequencer.sv
// Bench: two configurations (4 colours/gap 2, 3 colours/gap 0) on shared
// inputs, compared each cycle against a timeline model.
module tb_genius_sprite_sequencer;

  localparam int NI   = 2;
  localparam int HOLD = 4;
  localparam int ENDC = 3;

  logic       CLK = 1'b0;
  logic       RESET, PWR_BTN, COLOR_VALID, LOSE_REQ, WIN_REQ;
  logic [1:0] COLOR_IDX;
  logic       ack0, ack1, busy0, busy1;
  logic [6:0] fl0;
  logic [5:0] fl1;

  always #5 CLK = ~CLK;

  genius_sprite_sequencer u0 (
    .CLK(CLK), .RESET(RESET), .PWR_BTN(PWR_BTN), .COLOR_VALID(COLOR_VALID),
    .COLOR_IDX(COLOR_IDX), .COLOR_ACK(ack0), .LOSE_REQ(LOSE_REQ), .WIN_REQ(WIN_REQ),
    .SPRITES_FLAGS(fl0), .BUSY(busy0));

  genius_sprite_sequencer #(.NUM_COLORS(3), .GAP_CYCLES(0)) u1 (
    .CLK(CLK), .RESET(RESET), .PWR_BTN(PWR_BTN), .COLOR_VALID(COLOR_VALID),
    .COLOR_IDX(COLOR_IDX), .COLOR_ACK(ack1), .LOSE_REQ(LOSE_REQ), .WIN_REQ(WIN_REQ),
    .SPRITES_FLAGS(fl1), .BUSY(busy1));

  int tests = 0;
  int fails = 0;

  // Model: per-configuration timeline of "cycles left lit / dark / on end screen".
  int nc [NI] = '{4, 3};
  int gp [NI] = '{2, 0};
  bit m_on       [NI];
  int m_end      [NI];   // 0 none, 1 lose, 2 win
  int m_end_left [NI];
  int m_lit      [NI];
  int m_dark     [NI];
  int m_cur      [NI];
  int m_q        [NI][$];
  bit exp_ack    [NI];

  function automatic logic [7:0] exp_flags(int k);
    int f;
    if (m_end[k] == 1) return 8'h04;
    if (m_end[k] == 2) return 8'h02;
    if (!m_on[k])      return 8'h00;
    f = 1;
    if (m_lit[k] > 0) f = f | (1 << (nc[k] + 2 - m_cur[k]));
    return 8'(f);
  endfunction

  function automatic logic [7:0] exp_busy(int k);
    return {7'd0, (m_lit[k] > 0 || m_dark[k] > 0 || m_q[k].size() > 0)};
  endfunction

  task automatic clear_show(int k);
    m_lit[k] = 0; m_dark[k] = 0; m_q[k].delete();
  endtask

  task automatic model_step(int k);
    bit inr, accept, done, req;
    exp_ack[k] = 1'b0;
    if (RESET) begin
      m_on[k] = 0; m_end[k] = 0; m_end_left[k] = 0; clear_show(k);
      return;
    end
    if (m_end[k] != 0) begin
      req = (m_end[k] == 1) ? LOSE_REQ : WIN_REQ;
      if (m_end_left[k] <= 1 && !req) m_end[k] = 0;
      else if (m_end_left[k] > 1)     m_end_left[k]--;
    end else if (!m_on[k]) begin
      if (PWR_BTN) m_on[k] = 1;
    end else if (LOSE_REQ || WIN_REQ) begin
      m_on[k] = 0; m_end[k] = LOSE_REQ ? 1 : 2; m_end_left[k] = ENDC; clear_show(k);
    end else begin
      inr = COLOR_VALID && (int'(COLOR_IDX) < nc[k]);
      if (m_lit[k] == 0 && m_dark[k] == 0) begin
        if (inr) begin exp_ack[k] = 1; m_cur[k] = int'(COLOR_IDX); m_lit[k] = HOLD; end
      end else begin
        accept = inr && m_q[k].size() == 0;
        exp_ack[k] = accept;
        done = 0;
        if (m_lit[k] > 0) begin
          m_lit[k]--;
          if (m_lit[k] == 0) begin m_dark[k] = gp[k]; done = (gp[k] == 0); end
        end else begin
          m_dark[k]--;
          done = (m_dark[k] == 0);
        end
        if (done) begin
          if (m_q[k].size() > 0) begin m_cur[k] = m_q[k].pop_front(); m_lit[k] = HOLD; end
          else if (accept) begin m_cur[k] = int'(COLOR_IDX); m_lit[k] = HOLD; accept = 0; end
        end
        if (accept) m_q[k].push_back(int'(COLOR_IDX));
      end
    end
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: ack checked mid-cycle, flags/busy just after the edge.
  task automatic cycle();
    @(negedge CLK);
    for (int k = 0; k < NI; k++) model_step(k);
    chk("ack0", {7'd0, ack0}, {7'd0, exp_ack[0]});
    chk("ack1", {7'd0, ack1}, {7'd0, exp_ack[1]});
    @(posedge CLK);
    #1;
    chk("flags0", {1'b0, fl0}, exp_flags(0));
    chk("flags1", {2'b0, fl1}, exp_flags(1));
    chk("busy0", {7'd0, busy0}, exp_busy(0));
    chk("busy1", {7'd0, busy1}, exp_busy(1));
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Hold a colour request until the 4-colour instance accepts it.
  task automatic req(int idx);
    bit got;
    got = 0;
    COLOR_VALID = 1'b1;
    COLOR_IDX   = 2'(idx);
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      got = exp_ack[0];
    end
    chk("req_timeout", {7'd0, got}, 8'h01);
    COLOR_VALID = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; PWR_BTN = 1'b0; COLOR_VALID = 1'b0; COLOR_IDX = '0;
    LOSE_REQ = 1'b0; WIN_REQ = 1'b0;
    @(posedge CLK); #1;

    // Power-up
    cycles(2);
    chk("reset_flags", {1'b0, fl0}, 8'h00);
    chk("reset_busy", {7'd0, busy0}, 8'h00);
    RESET = 1'b0;
    PWR_BTN = 1'b1; cycle(); PWR_BTN = 1'b0;
    chk("pwr_flags", {1'b0, fl0}, 8'h01);

    // Single colour
    req(2);
    chk("show2", {1'b0, fl0}, 8'h11);
    cycles(6);
    chk("ready_flags", {1'b0, fl0}, 8'h01);
    chk("ready_busy", {7'd0, busy0}, 8'h00);

    // Back-to-back same colour
    req(0); cycle(); req(0);
    cycles(12);

    // Stall: three requests into one SHOW
    req(1); req(2); req(3); req(0);
    cycles(30);

    // Preempt with slot full
    req(1); req(2);
    LOSE_REQ = 1'b1; cycle(); LOSE_REQ = 1'b0;
    chk("lose0", {1'b0, fl0}, 8'h04);
    cycles(2);
    chk("lose2", {1'b0, fl0}, 8'h04);
    cycle();
    chk("lose_off", {1'b0, fl0}, 8'h00);

    // Out-of-range colour on the 3-colour instance
    PWR_BTN = 1'b1; cycle(); PWR_BTN = 1'b0;
    req(3);
    chk("oor_ack1", {7'd0, ack1}, 8'h00);
    chk("oor_flags1", {2'b0, fl1}, 8'h01);
    cycles(8);

    // LOSE and WIN together
    LOSE_REQ = 1'b1; WIN_REQ = 1'b1; cycles(2);
    chk("lose_win", {1'b0, fl0}, 8'h04);
    LOSE_REQ = 1'b0; WIN_REQ = 1'b0; cycles(4);

    // Reset mid-GAP
    PWR_BTN = 1'b1; cycle(); PWR_BTN = 1'b0;
    req(2); cycles(4);
    chk("in_gap", {1'b0, fl0}, 8'h01);
    RESET = 1'b1; cycle(); RESET = 1'b0;
    chk("reset_gap", {1'b0, fl0}, 8'h00);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      RESET    = ($urandom_range(0, 99) == 0);
      PWR_BTN  = ($urandom_range(0, 7) == 0);
      LOSE_REQ = ($urandom_range(0, 39) == 0);
      WIN_REQ  = ($urandom_range(0, 39) == 0);
      if (!COLOR_VALID && $urandom_range(0, 1) == 1) begin
        COLOR_VALID = 1'b1;
        COLOR_IDX   = 2'($urandom_range(0, 3));
      end
      cycle();
      if (exp_ack[0] || RESET) COLOR_VALID = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
